// File: rtl/sce_apbm_pkg.sv
// Shared types for the SCE APB command sequencer: command opcodes,
// response error codes and FSM states.
package sce_apbm_pkg;

    typedef enum logic [1:0] {
        WR   = 2'b00,
        RD   = 2'b01,
        POLL = 2'b10,
        RSV  = 2'b11
    } apbm_op_e;

    typedef enum logic [1:0] {
        OK     = 2'b00,
        SLVERR = 2'b01,
        TMO    = 2'b10,
        BADOP  = 2'b11
    } apbm_err_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        GAP    = 3'd3,
        RESP   = 3'd4
    } apbm_st_e;

endpackage

// File: rtl/apbif.sv
// APB3 bus bundle shared by the SCE sequencer and its register slaves.
interface apbif #(
    parameter int AW = 12
) ();
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/sce_apbm_seq.sv
// APB initiator: turns write/read/poll commands into APB transfers and
// returns one response (read data + error code) per command.
module sce_apbm_seq
    import sce_apbm_pkg::*;
#(
    parameter int AW   = 12,
    parameter int PTO  = 255,
    parameter int PGAP = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [31:0]   cmd_wdata,
    input  logic [31:0]   cmd_mask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic [1:0]    rsp_err,
    output logic          busy,
    apbif.master          apbm
);

    localparam int PCW   = ($clog2(PTO + 1) > 8) ? $clog2(PTO + 1) : 8;
    localparam int GW    = (PGAP > 1) ? $clog2(PGAP + 1) : 1;
    localparam int GLAST = (PGAP > 0) ? PGAP - 1 : 0;

    apbm_st_e      state, state_d;
    apbm_op_e      op_q;
    apbm_err_e     err_q, err_d;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mask_q;
    logic [31:0]   rdata_q;
    logic [PCW-1:0] pollcnt;
    logic [GW-1:0] gapcnt;
    logic          accept;
    logic          xfer_done;
    logic          poll_match;
    logic          cnt_inc;
    logic          sel;

    // Both streams use valid/ready: a beat transfers on a rising edge where
    // valid and ready are both high; valid never waits on ready, and the
    // producer holds its payload stable until the transfer happens.
    assign accept     = (state == IDLE) && cmd_valid;
    assign xfer_done  = (state == ACCESS) && apbm.pready;
    assign poll_match = ((apbm.prdata ^ wdata_q) & mask_q) == 32'h0;

    always_comb begin
        state_d = state;
        err_d   = err_q;
        cnt_inc = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (apbm_op_e'(cmd_op) == RSV) begin
                        state_d = RESP;
                        err_d   = BADOP;
                    end else begin
                        state_d = SETUP;
                        err_d   = OK;
                    end
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (apbm.pready) begin
                    if (op_q != POLL || apbm.pslverr) begin
                        state_d = RESP;
                        err_d   = apbm.pslverr ? SLVERR : OK;
                    end else if (poll_match) begin
                        state_d = RESP;
                        err_d   = OK;
                    end else if (pollcnt == PCW'(PTO)) begin
                        state_d = RESP;
                        err_d   = TMO;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = (PGAP == 0) ? SETUP : GAP;
                    end
                end
            end
            GAP: begin
                if (gapcnt == GW'(GLAST)) state_d = SETUP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            err_q   <= OK;
            op_q    <= WR;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            pollcnt <= '0;
            gapcnt  <= '0;
        end else begin
            state <= state_d;
            err_q <= err_d;
            if (accept) begin
                op_q    <= apbm_op_e'(cmd_op);
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                mask_q  <= cmd_mask;
                rdata_q <= '0;
                pollcnt <= '0;
            end
            // Every completed read overwrites, so a timed-out poll reports its last sample.
            if (xfer_done && op_q != WR) rdata_q <= apbm.prdata;
            if (cnt_inc && pollcnt != '1) pollcnt <= pollcnt + PCW'(1);
            if (state == GAP) gapcnt <= gapcnt + GW'(1);
            else              gapcnt <= '0;
        end
    end

    assign sel          = (state == SETUP) || (state == ACCESS);
    assign apbm.psel    = sel;
    assign apbm.penable = (state == ACCESS);
    assign apbm.pwrite  = sel && (op_q == WR);
    assign apbm.paddr   = addr_q;
    assign apbm.pwdata  = wdata_q;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_sce_apbm_seq.sv
// Self-checking bench for sce_apbm_seq: main instance (PTO=255, PGAP=3)
// with a programmable slave, plus a PTO=3/PGAP=0 instance for timeouts.
module tb_sce_apbm_seq;
    import sce_apbm_pkg::*;

    localparam int AW   = 12;
    localparam int PGAP = 3;

    // clock / reset
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [31:0]   cmd_mask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_err;
    logic          busy;

    logic          t_cmd_valid = 1'b0;
    logic          t_cmd_ready;
    logic [1:0]    t_cmd_op = 2'b00;
    logic [AW-1:0] t_cmd_addr = '0;
    logic [31:0]   t_cmd_wdata = '0;
    logic [31:0]   t_cmd_mask = '0;
    logic          t_rsp_valid;
    logic          t_rsp_ready = 1'b1;
    logic [31:0]   t_rsp_rdata;
    logic [1:0]    t_rsp_err;
    logic          t_busy;

    apbif #(.AW(AW)) bus ();
    apbif #(.AW(AW)) bus_t ();

    sce_apbm_seq #(.AW(AW), .PTO(255), .PGAP(PGAP)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy), .apbm(bus.master)
    );

    sce_apbm_seq #(.AW(AW), .PTO(3), .PGAP(0)) dut_t (
        .clk(clk), .resetn(resetn),
        .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_op(t_cmd_op),
        .cmd_addr(t_cmd_addr), .cmd_wdata(t_cmd_wdata), .cmd_mask(t_cmd_mask),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_rdata(t_rsp_rdata),
        .rsp_err(t_rsp_err), .busy(t_busy), .apbm(bus_t.master)
    );

    // never-matching zero-wait slave for the timeout instance
    int t_reads = 0;
    assign bus_t.pready  = 1'b1;
    assign bus_t.prdata  = 32'h0000_0055;
    assign bus_t.pslverr = 1'b0;
    always @(posedge clk)
        if (bus_t.psel && bus_t.penable && bus_t.pready) t_reads <= t_reads + 1;

    // programmable slave for the main instance: slv_a for reads below slv_n_a, then slv_b
    int          slv_wait = 0;
    int          slv_n_a = 0;
    logic [31:0] slv_a = '0;
    logic [31:0] slv_b = '0;
    logic        slv_err = 1'b0;
    int          wcnt = 0;
    int          nreads = 0;
    int          pen_cyc = 0;
    int          psel_cyc = 0;
    int          cyc = 0;
    int          setup_q[$];

    assign bus.pready  = bus.penable && (wcnt >= slv_wait);
    assign bus.prdata  = (nreads < slv_n_a) ? slv_a : slv_b;
    assign bus.pslverr = slv_err && bus.pready;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.psel) psel_cyc <= psel_cyc + 1;
        if (bus.penable) pen_cyc <= pen_cyc + 1;
        if (bus.psel && !bus.penable) setup_q.push_back(cyc);
        if (bus.psel && bus.penable) begin
            if (bus.pready) begin
                nreads <= nreads + 1;
                wcnt   <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // scoreboard
    logic [33:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic          rv_d = 1'b0;
    int            rv_cyc = 0;
    logic [AW-1:0] su_addr = '0;
    logic          su_write = 1'b0;
    logic [31:0]   su_wdata = '0;

    always @(negedge clk) begin
        logic [33:0] e;
        if (rsp_valid && !rv_d) rv_cyc = cyc;
        rv_d = rsp_valid;
        if (rsp_valid) check("rsp_vs_cmd_ready", cmd_ready, 0);
        if (bus.psel && !bus.penable) begin
            su_addr  = bus.paddr;
            su_write = bus.pwrite;
            su_wdata = bus.pwdata;
        end
        if (bus.psel && bus.penable)
            check("apb_stable", {bus.paddr, bus.pwrite, bus.pwdata}, {su_addr, su_write, su_wdata});
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e[31:0]);
                check("rsp_err", rsp_err, e[33:32]);
            end
        end
    end

    // driver tasks
    int acc_cyc = 0;

    task automatic drive(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mask);
        int n = 0;
        @(posedge clk); #2;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_mask  = mask;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 1, 0);
        acc_cyc = cyc;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        cmd_mask  = $urandom;
    endtask

    task automatic send(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mask,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_err);
        exp_q.push_back({exp_err, exp_rdata});
        drive(op, addr, wdata, mask);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, r0, e0, base, n;
        logic [31:0] d;
        int w;

        repeat (3) @(negedge clk);
        check("rst_apb", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 0);
        check("rst_rsp", {rsp_valid, rsp_rdata, rsp_err, busy}, 0);
        @(posedge clk); #2;
        resetn = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_rst", cmd_ready, 1);

        // zero-wait write
        slv_a = 32'hAAAA_5555; slv_n_a = nreads + 100; slv_wait = 0;
        p0 = psel_cyc;
        send(WR, 12'h004, 32'h1F, $urandom, 32'h0, OK);
        wait_done();
        check("wr_latency", rv_cyc - acc_cyc, 3);
        check("wr_apb_fields", {su_addr, su_write, su_wdata}, {12'h004, 1'b1, 32'h1F});
        check("wr_psel_cycles", psel_cyc - p0, 2);

        // read with two wait states
        slv_a = 32'hDEAD_BEEF; slv_n_a = nreads + 100; slv_wait = 2;
        e0 = pen_cyc;
        send(RD, 12'h024, $urandom, $urandom, 32'hDEAD_BEEF, OK);
        wait_done();
        check("rd_penable_cycles", pen_cyc - e0, 3);
        check("rd_latency", rv_cyc - acc_cyc, 5);
        check("rd_apb_fields", {su_addr, su_write}, {12'h024, 1'b0});

        // poll that matches on the fifth read
        slv_wait = 0; slv_a = 32'h2; slv_b = 32'h0; slv_n_a = nreads + 4;
        r0 = nreads; base = setup_q.size();
        send(POLL, 12'h010, 32'h0, 32'h1E, 32'h0, OK);
        wait_done();
        check("poll_reads", nreads - r0, 5);
        check("poll_latency", rv_cyc - acc_cyc, 23);
        check("poll_write", su_write, 0);
        for (int i = base + 1; i < setup_q.size(); i++)
            check("poll_spacing", setup_q[i] - setup_q[i-1], 2 + PGAP);

        // poll timeout on the PTO=3, PGAP=0 instance
        r0 = t_reads;
        @(posedge clk); #2;
        t_cmd_valid = 1'b1; t_cmd_op = POLL; t_cmd_addr = 12'h030;
        t_cmd_wdata = 32'h0; t_cmd_mask = 32'hFF;
        @(negedge clk);
        check("t_cmd_ready", t_cmd_ready, 1);
        acc_cyc = cyc;
        @(posedge clk); #2;
        t_cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!t_rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t_rsp_seen", t_rsp_valid, 1);
        check("t_latency", cyc - acc_cyc, 9);
        check("t_rdata", t_rsp_rdata, 32'h55);
        check("t_err", t_rsp_err, TMO);
        check("t_reads", t_reads - r0, 4);

        // slave error on read, then a reserved opcode
        slv_err = 1'b1; slv_a = 32'h1234_5678; slv_n_a = nreads + 100;
        send(RD, 12'h008, $urandom, $urandom, 32'h1234_5678, SLVERR);
        wait_done();
        slv_err = 1'b0;
        p0 = psel_cyc;
        send(RSV, 12'h00C, $urandom, $urandom, 32'h0, BADOP);
        wait_done();
        check("badop_psel_cycles", psel_cyc - p0, 0);
        check("badop_latency", rv_cyc - acc_cyc, 1);

        // poll hit by pslverr stops after one read
        slv_err = 1'b1; slv_a = 32'h0000_00F0; slv_n_a = nreads + 100;
        r0 = nreads;
        send(POLL, 12'h010, 32'h0, 32'hFF, 32'h0000_00F0, SLVERR);
        wait_done();
        slv_err = 1'b0;
        check("poll_err_reads", nreads - r0, 1);

        // mask of zero matches on the first read
        d = $urandom; slv_a = d; slv_n_a = nreads + 100;
        r0 = nreads;
        send(POLL, 12'h020, $urandom, 32'h0, d, OK);
        wait_done();
        check("mask0_reads", nreads - r0, 1);

        // random reads with random wait states
        for (int k = 0; k < 4; k++) begin
            w = $urandom_range(0, 3);
            d = $urandom;
            slv_wait = w; slv_a = d; slv_n_a = nreads + 100;
            send(RD, AW'($urandom_range(0, 1023) * 4), $urandom, $urandom, d, OK);
            wait_done();
            check("rnd_rd_latency", rv_cyc - acc_cyc, 3 + w);
        end

        // reset during ACCESS with the response side stalled
        slv_wait = 10;
        send(RD, 12'h040, $urandom, $urandom, 32'h0, OK);
        n = 0;
        @(negedge clk);
        while (!bus.penable && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_in_access", bus.penable, 1);
        @(posedge clk); #2;
        rsp_ready = 1'b0;
        resetn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_apb", {bus.psel, bus.penable}, 0);
        check("rst_mid_rsp", {rsp_valid, busy}, 0);
        @(posedge clk); #2;
        resetn = 1'b1;
        @(negedge clk);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        repeat (4) begin
            @(negedge clk);
            check("rst_mid_no_rsp", rsp_valid, 0);
        end
        rsp_ready = 1'b1;
        slv_wait = 0; d = $urandom; slv_a = d; slv_n_a = nreads + 100;
        send(RD, 12'h03C, $urandom, $urandom, d, OK);
        wait_done();
        check("post_rst_latency", rv_cyc - acc_cyc, 3);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
